iter_shift_unit: RTL and testbench
==================================

// Module: iter_shift_unit
// PURPOSE
//  Multi-cycle shifter for the 32-bit MIPS R-type datapath (srl/sll/sra).
//  Holds the operand in a working register and moves it one bit position per
//  clock through a single-level 1-bit shift stage, feeding that stage's output
//  back into the register. Its start/busy/done handshake lets the ALU control
//  stall for shift instructions without instantiating a full barrel shifter.
// PARAMETERS
//  WIDTH    32  operand/result width in bits
//  SHAMT_W   5  shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        synchronous, active-high reset
//  start     in   1        request a shift; sampled only when busy==0
//  op        in   2        00=srl, 01=sll, 10=sra, 11=treated as srl
//  data_in   in   WIDTH    operand (rt), latched when start is accepted
//  shamt     in   SHAMT_W  shift amount, latched when start is accepted
//  busy      out  1        high while the FSM is in SHIFT
//  done      out  1        one-cycle pulse: result is final
//  result    out  WIDTH    working register; final value valid from the done cycle
// BEHAVIOUR
//  Reset: state=IDLE, result=0, count=0, busy=0, done=0. A reset asserted
//   mid-operation aborts that operation. done does not pulse for it, and the
//   latched op and count are discarded.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE  : start=1 -> result<=data_in, op_r<=op, count<=shamt.
//           Next state is DONE if shamt==0, otherwise SHIFT.
//   SHIFT : result<=shift1(result, op_r), count<=count-1.
//           If count==1 the next state is DONE, otherwise stay in SHIFT.
//   DONE  : done=1 for this cycle only. start=1 is accepted exactly as in
//           IDLE (back-to-back operation). Otherwise the next state is IDLE.
//  Acceptance: start is accepted when busy==0 (IDLE or DONE). start while
//   busy==1 is ignored; no latching and no queuing.
//  shift1 on WIDTH bits:
//   srl: {1'b0, r[W-1:1]}
//   sll: {r[W-2:0], 1'b0}
//   sra: {r[W-1], r[W-1:1]}
//  Latency: start accepted at edge T0 -> done high in cycle T0+shamt+1.
//   Gives 1 cycle for shamt=0 and 32 cycles for shamt=31.
//   busy is high for exactly shamt cycles.
//  result changes every SHIFT cycle. It holds its final value from the done
//   cycle until the next accepted start.
//  count never underflows: SHIFT is never entered with count==0.
//  busy and done are never high together.
//  Outputs are registered or decoded from state only; there is no
//   combinational path from any input to busy, done or result.
// TESTING
//  1 srl, data_in=0x80000000, shamt=31 -> done at cycle 32, result=0x00000001;
//    busy high for 31 cycles.
//  2 sra, data_in=0x80000000, shamt=4 -> done at cycle 5, result=0xF8000000.
//    Same operand with srl -> 0x08000000.
//  3 sll, data_in=0x00000001, shamt=0 -> done at cycle 1, result=0x00000001,
//    busy never high. sll with shamt=31 -> result=0x80000000.
//  4 start srl 0xFFFF0000 shamt=8, then pulse start (sll, shamt=1) at cycle 3
//    -> the second start is ignored; done at cycle 9, result=0x00FFFF00.
//  5 start sra 0x80000000 shamt=20, assert reset at cycle 6 -> next cycle has
//    state IDLE, result=0, busy=0, and no done pulse. A new srl 0x10 shamt=4
//    then yields 0x00000001.
//  6 in the done cycle of sll 0x1 shamt=2 (result=0x4), apply start srl
//    0x100 shamt=8 -> accepted; done 9 cycles later, result=0x00000001.

Source files
------------

// File: rtl/iter_shift_unit.sv
// -----------------------------------------------------------------------------
// iter_shift_unit
//   Multi-cycle shifter for the 32-bit MIPS R-type datapath (srl/sll/sra).
//   The operand is held in a working register and moved one bit per clock
//   through a single 1-bit shift stage whose output feeds back into that
//   register. A start/busy/done handshake lets the ALU control stall for
//   shift instructions instead of using a full barrel shifter.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; result holds the last final value
//   SHIFT | one 1-bit shift per cycle; count = shifts still to do
//   DONE  | result final, done pulses; start is accepted as in IDLE
//
// Parameters
//   WIDTH    operand/result width (default 32)
//   SHAMT_W  shift-amount width, must equal clog2(WIDTH) (default 5)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset; aborts an operation in flight
//   start    in   shift request, sampled only while busy is low
//   op       in   00=srl, 01=sll, 10=sra, 11=srl
//   data_in  in   operand, latched on an accepted start
//   shamt    in   shift amount, latched on an accepted start
//   busy     out  high while in SHIFT
//   done     out  one-cycle pulse, result is final
//   result   out  working register
// -----------------------------------------------------------------------------
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Single-level 1-bit shift stage; op 11 falls through to srl.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] r,
                                              input logic [1:0]       o);
    logic [WIDTH-1:0] s;
    case (o)
      OP_SLL:  s = {r[WIDTH-2:0], 1'b0};
      OP_SRA:  s = {r[WIDTH-1], r[WIDTH-1:1]};
      OP_SRL:  s = {1'b0, r[WIDTH-1:1]};
      default: s = {1'b0, r[WIDTH-1:1]};
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    count_d  = count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          result_d = data_in;
          op_d     = op;
          count_d  = shamt;
          // A zero shift amount never enters SHIFT, so count cannot underflow.
          state_d  = (shamt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        result_d = shift1(result_q, op_q);
        count_d  = count_q - CNT_ONE;
        state_d  = (count_q == CNT_ONE) ? ST_DONE : ST_SHIFT;
      end
      default: begin
        state_d  = ST_IDLE;
      end
    endcase

    // Flags are registered from the next state so they line up with state_q.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      op_q     <= OP_SRL;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int errors;

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one start, then watches cycles (1 = first cycle after the accepting
  // edge) until done or the bound. Optionally injects a second start at inj_at.
  task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                        input int inj_at, input logic [1:0] inj_op,
                        input logic [31:0] inj_d, input logic [4:0] inj_s,
                        output int done_cyc, output int busy_cyc, output logic overlap);
    int cyc;
    start   = 1'b1;
    op      = o;
    data_in = d;
    shamt   = s;
    step();
    start    = 1'b0;
    cyc      = 1;
    busy_cyc = 0;
    overlap  = 1'b0;
    while (done !== 1'b1 && cyc <= 64) begin
      if (busy === 1'b1) busy_cyc++;
      if (cyc == inj_at) begin
        start   = 1'b1;
        op      = inj_op;
        data_in = inj_d;
        shamt   = inj_s;
      end
      step();
      start = 1'b0;
      cyc++;
    end
    if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    done_cyc = (done === 1'b1) ? cyc : -1;
  endtask

  initial begin
    int          dc;
    int          bc;
    logic        ov;
    logic        seen_done;

    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    data_in = 32'h0;
    shamt   = 5'd0;

    step();
    step();
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    reset = 1'b0;
    step();

    // 1: srl 0x80000000 >> 31
    run_op(2'b00, 32'h8000_0000, 5'd31, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t1_done_cyc", dc, 32'd32);
    check("t1_result", result, 32'h0000_0001);
    check("t1_busy_cycles", bc, 32'd31);
    check("t1_overlap", {31'b0, ov}, 32'h0);
    step();
    check("t1_done_pulse", {31'b0, done}, 32'h0);
    check("t1_result_hold", result, 32'h0000_0001);

    // 2: sra / srl of 0x80000000 by 4
    run_op(2'b10, 32'h8000_0000, 5'd4, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t2_sra_done_cyc", dc, 32'd5);
    check("t2_sra_result", result, 32'hF800_0000);
    check("t2_sra_busy_cycles", bc, 32'd4);
    step();
    run_op(2'b00, 32'h8000_0000, 5'd4, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t2_srl_result", result, 32'h0800_0000);
    step();
    run_op(2'b11, 32'h8000_0000, 5'd4, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t2_op11_result", result, 32'h0800_0000);
    step();

    // 3: sll by 0 and by 31
    run_op(2'b01, 32'h0000_0001, 5'd0, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t3_sh0_done_cyc", dc, 32'd1);
    check("t3_sh0_result", result, 32'h0000_0001);
    check("t3_sh0_busy_cycles", bc, 32'd0);
    check("t3_sh0_busy_now", {31'b0, busy}, 32'h0);
    step();
    run_op(2'b01, 32'h0000_0001, 5'd31, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t3_sh31_done_cyc", dc, 32'd32);
    check("t3_sh31_result", result, 32'h8000_0000);
    step();

    // 4: start while busy is ignored
    run_op(2'b00, 32'hFFFF_0000, 5'd8, 3, 2'b01, 32'h1234_5678, 5'd1, dc, bc, ov);
    check("t4_done_cyc", dc, 32'd9);
    check("t4_result", result, 32'h00FF_FF00);
    check("t4_busy_cycles", bc, 32'd8);
    step();
    check("t4_no_second_op", {30'b0, busy, done}, 32'h0);

    // 5: reset mid-operation
    start   = 1'b1;
    op      = 2'b10;
    data_in = 32'h8000_0000;
    shamt   = 5'd20;
    step();
    start = 1'b0;
    repeat (5) step();
    check("t5_busy_before_rst", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    step();
    check("t5_rst_busy", {31'b0, busy}, 32'h0);
    check("t5_rst_done", {31'b0, done}, 32'h0);
    check("t5_rst_result", result, 32'h0);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    check("t5_no_done_after_abort", {31'b0, seen_done}, 32'h0);
    run_op(2'b00, 32'h0000_0010, 5'd4, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t5_new_done_cyc", dc, 32'd5);
    check("t5_new_result", result, 32'h0000_0001);
    step();

    // 6: back-to-back start in the done cycle
    run_op(2'b01, 32'h0000_0001, 5'd2, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t6_first_done_cyc", dc, 32'd3);
    check("t6_first_result", result, 32'h0000_0004);
    run_op(2'b00, 32'h0000_0100, 5'd8, 0, 2'b00, 32'h0, 5'd0, dc, bc, ov);
    check("t6_second_done_cyc", dc, 32'd9);
    check("t6_second_result", result, 32'h0000_0001);
    check("t6_overlap", {31'b0, ov}, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
